// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, evaluated result and status flags out.
interface expr_eval_if #(parameter int WIDTH = 16);
  logic [7:0]       in;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             err;
  logic             ovf;
  modport master (output in, input result, valid, err, ovf);
  modport slave  (input in, output result, valid, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: incremental evaluator of single-digit '+'/'*' expressions with precedence.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        clr,
  expr_eval_if.slave bus
);
  localparam logic [1:0] S_DIG = 2'd0;
  localparam logic [1:0] S_OP  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;
  localparam int W2 = 2 * WIDTH;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, term_q, term_d, result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             is_dig, is_plus, is_mul, is_idle;
  logic [W2-1:0]    d_w, prod_w, sum_w, res_w;
  always_comb begin
    is_dig  = bus.in >= 8'h30 && bus.in <= 8'h39;
    is_plus = bus.in == 8'h2B;
    is_mul  = bus.in == 8'h2A;
    is_idle = bus.in == 8'h00;
    d_w     = {{(W2-8){1'b0}}, bus.in - 8'h30};
    prod_w  = {{WIDTH{1'b0}}, term_q} * d_w;
    sum_w   = {{WIDTH{1'b0}}, sum_q} + {{WIDTH{1'b0}}, term_q};
    res_w   = {{WIDTH{1'b0}}, sum_q} + {{WIDTH{1'b0}}, prod_w[WIDTH-1:0]};
    state_d  = state_q;
    sum_d    = sum_q;
    term_d   = term_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (!is_idle && state_q == S_DIG) begin
      state_d = is_dig ? S_OP : S_ERR;
      if (is_dig) begin
        term_d   = prod_w[WIDTH-1:0];
        result_d = res_w[WIDTH-1:0];
        ovf_d    = ovf_q | (|prod_w[W2-1:WIDTH]) | (|res_w[W2-1:WIDTH]);
      end
    end else if (!is_idle && state_q == S_OP) begin
      state_d = (is_plus || is_mul) ? S_DIG : S_ERR;
      if (is_plus) begin
        sum_d  = sum_w[WIDTH-1:0];
        term_d = WIDTH'(1);
        ovf_d  = ovf_q | (|sum_w[W2-1:WIDTH]);
      end
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_DIG;
      sum_q    <= '0;
      term_q   <= WIDTH'(1);
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
  assign bus.result = result_q;
  assign bus.valid  = state_q == S_OP;
  assign bus.err    = state_q == S_ERR;
  assign bus.ovf    = ovf_q;
endmodule
